mult_hilo_ctrl: RTL and testbench
=================================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MULTU, 6'd25, multiply-unsigned function code.
- MFHI, 6'd16, move-from-HI function code.
- MFLO, 6'd18, move-from-LO function code.
- N_ITER, 32, shift-add iterations per multiply.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk: input, 1, sole clock, rising edge.
- reset: input, 1, asynchronous, active-low.
- start: input, 1, pulse requesting a multiply.
- funct: input, 6, function code qualifying start/rd_req.
- opA: input, 32, multiplicand.
- opB: input, 32, multiplier.
- rd_req: input, 1, MFHI/MFLO read request.
- mul_product: input, 64, product returned by the shift-add multiplier.
- mul_signal: output, 6, control code to the multiplier.
- mul_a: output, 32, multiplicand to the multiplier.
- mul_b: output, 32, multiplier operand to the multiplier.
- busy: output, 1, pipeline stall request.
- done: output, 1, one-cycle completion pulse.
- hi: output, 32, HI register.
- lo: output, 32, LO register.
- rd_data: output, 32, MFHI/MFLO result.
- rd_valid: output, 1, rd_data is valid this cycle.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, RUN, CAPTURE; all transitions occur on the rising edge of clk.
REQ-004 IDLE→LOAD SHALL occur when start=1 and funct==MULTU; opA/opB are latched into internal op registers on that edge.
- In any other state, start SHALL be ignored: no re-latch, no restart.
- In IDLE, start with funct≠MULTU SHALL be ignored.
REQ-005 LOAD SHALL last exactly 1 cycle, then go to RUN.
- During LOAD, mul_signal SHALL equal MULTU (0→MULTU transition loads the multiplier).
- The 5-bit iteration counter SHALL be cleared to 0 in LOAD.
REQ-006 RUN SHALL last exactly N_ITER cycles.
- mul_signal SHALL hold MULTU throughout RUN.
- The counter SHALL increment each cycle; the cycle with count==31 is the last RUN cycle.
- No wrap past 31 is permitted.
REQ-007 CAPTURE SHALL last 1 cycle.
- mul_signal SHALL be 0 during CAPTURE.
- hi←mul_product[63:32] and lo←mul_product[31:0] on the edge leaving CAPTURE.
- done=1 for exactly the cycle after that edge; the next state is IDLE.
REQ-008 mul_signal SHALL be 0 in IDLE.
REQ-009 mul_a/mul_b SHALL be driven from the latched op registers and SHALL remain stable from LOAD through CAPTURE.
REQ-010 Latency: with start sampled at edge E0, hi/lo SHALL update at edge E0+34, and done SHALL be high in the cycle following E0+34.
REQ-011 busy SHALL be 1 in LOAD, RUN and CAPTURE and 0 in IDLE. busy is a registered state decode; it is not combinational from start.
REQ-012 rd_req with funct==MFHI SHALL give rd_data=hi, and with funct==MFLO SHALL give rd_data=lo.
- rd_data is combinational from the current hi/lo.
- rd_data=0 for any other funct or when rd_req=0.
REQ-013 rd_valid SHALL be rd_req & (funct==MFHI|funct==MFLO) & ~busy. A read during a multiply returns rd_valid=0; the pipeline holds on busy.
REQ-014 Simultaneous done cycle and rd_req: rd_valid=1 and rd_data reflects the newly written hi/lo.
REQ-015 Arithmetic is unsigned 32×32→64; no sign handling or overflow flag.

Reset
REQ-016 reset=0 SHALL asynchronously force the following, in any state including mid-RUN:
- state=IDLE, counter=0;
- hi=0, lo=0, op registers=0;
- mul_signal=0, busy=0, done=0.
REQ-017 After reset deasserts, the first start SHALL behave per REQ-004; no partial product survives reset.

Verification
REQ-018 opA=3, opB=5, MULTU start → busy=1 for 34 cycles, then hi=0x00000000, lo=0x0000000F, done pulse of exactly 1 cycle.
REQ-019 opA=opB=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 at E0+34.
REQ-020 Second start with opA=7 at count==10 of RUN → ignored; the result equals the first operands' product and completion is still at E0+34.
REQ-021 reset=0 at count==10 → immediately busy=0, mul_signal=0, hi=lo=0; restart with 2×9 → lo=0x00000012 after 34 cycles.
REQ-022 MFHI rd_req while busy → rd_valid=0. The same request in the done cycle after 0x10000×0x10000 → rd_valid=1, rd_data=0x00000001; MFLO → rd_data=0x00000000.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mult_hilo_ctrl
// Brief   : Sequences an external shift-add multiplier for MULTU; holds HI/LO
//           and answers MFHI/MFLO reads.
// Revision: 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl #(
    parameter logic [5:0] MULTU  = 6'd25,
    parameter logic [5:0] MFHI   = 6'd16,
    parameter logic [5:0] MFLO   = 6'd18,
    parameter int         N_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        rd_req,
    input  logic [63:0] mul_product,
    output logic [5:0]  mul_signal,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST = 5'(N_ITER - 1);

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_mul_signal;
    logic        r_busy;
    logic        r_done;

    logic        w_is_hi;
    logic        w_is_lo;

    // Outputs are updated alongside the state so they decode the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= 5'd0;
            r_op_a       <= 32'd0;
            r_op_b       <= 32'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_mul_signal <= 6'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (funct == MULTU)) begin
                        r_state      <= S_LOAD;
                        r_op_a       <= opA;
                        r_op_b       <= opB;
                        r_busy       <= 1'b1;
                        r_mul_signal <= MULTU;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    r_count <= 5'd0;
                end
                S_RUN: begin
                    // Counter holds on the last iteration instead of wrapping.
                    if (r_count == C_LAST) begin
                        r_state      <= S_CAPTURE;
                        r_mul_signal <= 6'd0;
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                S_CAPTURE: begin
                    r_hi    <= mul_product[63:32];
                    r_lo    <= mul_product[31:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_is_hi = (funct == MFHI);
    assign w_is_lo = (funct == MFLO);

    assign rd_data  = (rd_req && w_is_hi) ? r_hi :
                      (rd_req && w_is_lo) ? r_lo : 32'd0;
    assign rd_valid = rd_req & (w_is_hi | w_is_lo) & ~r_busy;

    assign mul_signal = r_mul_signal;
    assign mul_a      = r_op_a;
    assign mul_b      = r_op_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
`default_nettype none
// Testbench for mult_hilo_ctrl: directed and random multiplies against a
// plain-arithmetic reference, with a cycle-accurate multiplier stand-in.
module tb_mult_hilo_ctrl;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MFLO  = 6'd18;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [5:0]  funct  = 6'd0;
    logic [31:0] opA    = 32'd0;
    logic [31:0] opB    = 32'd0;
    logic        rd_req = 1'b0;
    logic [63:0] mul_product;
    logic [5:0]  mul_signal;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        rd_valid;

    int tests = 0;
    int fails = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    mult_hilo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .opA        (opA),
        .opB        (opB),
        .rd_req     (rd_req),
        .mul_product(mul_product),
        .mul_signal (mul_signal),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: loads on the 0->MULTU edge, product valid only
    // after 32 further MULTU cycles; garbage otherwise.
    logic        m_prev = 1'b0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;
    int          m_cnt  = 0;

    always @(posedge clk) begin
        if (mul_signal == MULTU && !m_prev) begin
            m_a   <= mul_a;
            m_b   <= mul_b;
            m_cnt <= 0;
        end else if (mul_signal == MULTU) begin
            m_cnt <= m_cnt + 1;
        end
        m_prev <= (mul_signal == MULTU);
    end

    assign mul_product = (m_cnt == 32) ? ({32'd0, m_a} * {32'd0, m_b})
                                       : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One multiply from start to one cycle past done. intf_cyc injects a
    // second start; rst_cyc pulls reset low mid-operation and returns.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int intf_cyc, input int rst_cyc);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        @(negedge clk);
        start = 1'b1; funct = MULTU; opA = a; opB = b;
        @(posedge clk);
        #1;
        start = 1'b0; funct = 6'd0; opA = $urandom; opB = $urandom;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == rst_cyc) begin
                reset = 1'b0;
                #1;
                ref_hi = 32'd0;
                ref_lo = 32'd0;
                chk("rst_busy", busy, 0);
                chk("rst_mul_signal", mul_signal, 0);
                chk("rst_hi", hi, 0);
                chk("rst_lo", lo, 0);
                chk("rst_done", done, 0);
                chk("rst_mul_a", mul_a, 0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("mul_signal", mul_signal, (k <= 33) ? MULTU : 6'd0);
            chk("mul_a", mul_a, a);
            chk("mul_b", mul_b, b);
            chk("hi_hold", hi, ref_hi);
            chk("lo_hold", lo, ref_lo);
            if (k == 5) begin
                rd_req = 1'b1; funct = MFHI;
                #1 chk("rd_valid_busy", rd_valid, 0);
                rd_req = 1'b0; funct = 6'd0;
            end
            if (k == intf_cyc) begin
                start = 1'b1; funct = MULTU; opA = 32'd7; opB = $urandom;
            end
            if (k == intf_cyc + 1) begin
                start = 1'b0; funct = 6'd0;
            end
        end
        @(negedge clk);
        ref_hi = p[63:32];
        ref_lo = p[31:0];
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("hi", hi, ref_hi);
        chk("lo", lo, ref_lo);
        chk("mul_signal_idle", mul_signal, 0);
        rd_req = 1'b1; funct = MFHI;
        #1;
        chk("mfhi_valid", rd_valid, 1);
        chk("mfhi_data", rd_data, ref_hi);
        funct = MFLO;
        #1;
        chk("mflo_valid", rd_valid, 1);
        chk("mflo_data", rd_data, ref_lo);
        rd_req = 1'b0; funct = 6'd0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_mul_signal", mul_signal, 0);
        chk("reset_mul_a", mul_a, 0);
        chk("reset_rd_valid", rd_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        // Start with a non-MULTU code is ignored.
        @(negedge clk);
        start = 1'b1; funct = MFHI; opA = 32'd11; opB = 32'd13;
        @(negedge clk);
        start = 1'b0; funct = 6'd0;
        chk("bad_start_busy", busy, 0);
        chk("bad_start_mul_signal", mul_signal, 0);

        run_mul(32'd3, 32'd5, 0, 0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_mul($urandom, $urandom, 12, 0);
        run_mul($urandom, $urandom, 0, 12);
        run_mul(32'd2, 32'd9, 0, 0);
        run_mul(32'h0001_0000, 32'h0001_0000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom, 0, 0);
        end

        // Idle reads with a non-read code or no request return nothing.
        @(negedge clk);
        rd_req = 1'b1; funct = MULTU;
        #1;
        chk("rd_other_data", rd_data, 0);
        chk("rd_other_valid", rd_valid, 0);
        rd_req = 1'b0; funct = MFHI;
        #1;
        chk("rd_noreq_data", rd_data, 0);
        chk("rd_noreq_valid", rd_valid, 0);
        funct = 6'd0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
